// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - branch prediction table and mispredict recovery sequencer
`timescale 1ns/1ps
module branch_resolve_ctrl #(
  parameter int XLEN     = 64,
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  id_pc,
  output logic             id_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_taken,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             stall,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  redirect_target,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic [0:0]          state;
  logic [1:0]          bht [ENTRIES];
  logic [XLEN-1:0]     pend_target;
  logic [IDX_BITS-1:0] pend_idx;
  logic                pend_taken;

  logic [IDX_BITS-1:0] id_idx, ex_idx, upd_idx;
  logic [XLEN-1:0]     ex_target;
  logic                resolve, mispred, fire_run, fire_pend, redirect;
  logic                upd_en, upd_taken;
  logic                unused_pc_bits;

  assign id_idx = id_pc[IDX_BITS+1:2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign unused_pc_bits = ^{id_pc[XLEN-1:IDX_BITS+2], id_pc[1:0],
                            ex_pc[XLEN-1:IDX_BITS+2], ex_pc[1:0]};

  // Lookup sees the pre-update entry when EX writes the same index this cycle.
  assign id_pred_taken = reset & bht[id_idx][1];

  assign resolve   = ex_valid & ex_branch;
  assign mispred   = resolve & (ex_taken != ex_pred_taken);
  assign ex_target = ex_taken ? (ex_pc + ex_imm) : (ex_pc + XLEN'(4));

  assign fire_run  = (state == RUN) & ~stall & mispred;
  assign fire_pend = (state == PENDING) & ~stall;
  assign redirect  = reset & (fire_run | fire_pend);

  assign pc_redirect     = redirect;
  assign flush_if_id     = redirect;
  assign flush_id_ex     = redirect;
  assign redirect_target = (state == PENDING) ? pend_target : ex_target;

  assign upd_en    = ~stall & (((state == RUN) & resolve) | (state == PENDING));
  assign upd_idx   = (state == PENDING) ? pend_idx : ex_idx;
  assign upd_taken = (state == PENDING) ? pend_taken : ex_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
      state            <= RUN;
      pend_target      <= '0;
      pend_idx         <= '0;
      pend_taken       <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (upd_en) begin
        if (upd_taken) begin
          if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'd1;
        end else begin
          if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'd1;
        end
        if (branch_count != '1) branch_count <= branch_count + CNT_W'(1);
      end
      if ((fire_run | fire_pend) && (mispredict_count != '1))
        mispredict_count <= mispredict_count + CNT_W'(1);

      case (state)
        RUN: begin
          // A mispredict under stall is parked until the pipeline can take the redirect.
          if (stall && mispred) begin
            pend_target <= ex_target;
            pend_idx    <= ex_idx;
            pend_taken  <= ex_taken;
            state       <= PENDING;
          end
        end
        default: begin
          if (!stall) state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - directed-vector bench for branch_resolve_ctrl
`timescale 1ns/1ps
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] id_pc;
  logic        id_pred_taken;
  logic        ex_valid, ex_branch, ex_taken, ex_pred_taken;
  logic [63:0] ex_pc, ex_imm;
  logic        stall;
  logic        pc_redirect, flush_if_id, flush_id_ex;
  logic [63:0] redirect_target;
  logic [31:0] branch_count, mispredict_count;

  int vecs = 0;
  int errs = 0;

  branch_resolve_ctrl #(.XLEN(64), .IDX_BITS(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_pc(id_pc), .id_pred_taken(id_pred_taken),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_taken(ex_taken),
    .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc), .ex_imm(ex_imm), .stall(stall),
    .pc_redirect(pc_redirect), .redirect_target(redirect_target),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic tk, input logic pt,
                        input logic [63:0] pc, input logic [63:0] imm, input logic st);
    ex_valid = v; ex_branch = v; ex_taken = tk; ex_pred_taken = pt;
    ex_pc = pc; ex_imm = imm; stall = st;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; id_pc = 64'h100;
    set_ex(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    tick();
    vecs++;
    if (id_pred_taken !== 1'b0) begin errs++; $display("FAIL reset_pred got %b exp 0", id_pred_taken); end
    vecs++;
    if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      errs++; $display("FAIL reset_counts got %0d/%0d exp 0/0", branch_count, mispredict_count);
    end
    vecs++;
    if ({pc_redirect, flush_if_id, flush_id_ex} !== 3'b000) begin
      errs++; $display("FAIL reset_outputs got %b exp 000", {pc_redirect, flush_if_id, flush_id_ex});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mispredict_taken();
    set_ex(1'b1, 1'b1, 1'b0, 64'h100, 64'h20, 1'b0);
    vecs++;
    if ({pc_redirect, flush_if_id, flush_id_ex} !== 3'b111 || redirect_target !== 64'h120) begin
      errs++; $display("FAIL mp_taken_pulse got %b tgt %h exp 111 tgt 120",
                       {pc_redirect, flush_if_id, flush_id_ex}, redirect_target);
    end
    vecs++;
    if (id_pred_taken !== 1'b0) begin errs++; $display("FAIL same_cycle_read got %b exp 0", id_pred_taken); end
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    vecs++;
    if (id_pred_taken !== 1'b1 || branch_count !== 32'd1 || mispredict_count !== 32'd1 || pc_redirect !== 1'b0) begin
      errs++; $display("FAIL mp_taken_after got pred %b cnt %0d/%0d redir %b exp 1 1/1 0",
                       id_pred_taken, branch_count, mispredict_count, pc_redirect);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 1'b1, 1'b1, 64'h100, 64'h20, 1'b0);
      vecs++;
      if (pc_redirect !== 1'b0) begin errs++; $display("FAIL correct_taken_%0d redir got %b exp 0", i, pc_redirect); end
      tick();
    end
    set_ex(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    vecs++;
    if (id_pred_taken !== 1'b1 || branch_count !== 32'd4 || mispredict_count !== 32'd1) begin
      errs++; $display("FAIL sat_state got pred %b cnt %0d/%0d exp 1 4/1", id_pred_taken, branch_count, mispredict_count);
    end
    set_ex(1'b1, 1'b0, 1'b1, 64'h100, 64'h20, 1'b0);
    vecs++;
    if (pc_redirect !== 1'b1 || redirect_target !== 64'h104) begin
      errs++; $display("FAIL mp_nt_pulse got %b tgt %h exp 1 tgt 104", pc_redirect, redirect_target);
    end
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    vecs++;
    if (id_pred_taken !== 1'b1 || branch_count !== 32'd5 || mispredict_count !== 32'd2) begin
      errs++; $display("FAIL mp_nt_after got pred %b cnt %0d/%0d exp 1 5/2", id_pred_taken, branch_count, mispredict_count);
    end
    set_ex(1'b1, 1'b0, 1'b0, 64'h100, 64'h20, 1'b0);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    vecs++;
    if (id_pred_taken !== 1'b0 || branch_count !== 32'd6 || mispredict_count !== 32'd2) begin
      errs++; $display("FAIL nt_correct got pred %b cnt %0d/%0d exp 0 6/2", id_pred_taken, branch_count, mispredict_count);
    end
  endtask

  task automatic test_stall_pending();
    id_pc = 64'h2000;
    set_ex(1'b1, 1'b1, 1'b0, 64'h2000, 64'h40, 1'b1);
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if ({pc_redirect, flush_if_id, flush_id_ex} !== 3'b000) begin
        errs++; $display("FAIL stalled_%0d outputs got %b exp 000", i, {pc_redirect, flush_if_id, flush_id_ex});
      end
      tick();
      set_ex(1'b1, 1'b0, 1'b1, 64'h500, 64'h8, 1'b1);
    end
    set_ex(1'b1, 1'b0, 1'b1, 64'h500, 64'h8, 1'b0);
    vecs++;
    if ({pc_redirect, flush_if_id, flush_id_ex} !== 3'b111 || redirect_target !== 64'h2040) begin
      errs++; $display("FAIL pending_release got %b tgt %h exp 111 tgt 2040",
                       {pc_redirect, flush_if_id, flush_id_ex}, redirect_target);
    end
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    vecs++;
    if (pc_redirect !== 1'b0 || id_pred_taken !== 1'b1 || branch_count !== 32'd7 || mispredict_count !== 32'd3) begin
      errs++; $display("FAIL pending_after got redir %b pred %b cnt %0d/%0d exp 0 1 7/3",
                       pc_redirect, id_pred_taken, branch_count, mispredict_count);
    end
    tick();
    vecs++;
    if (branch_count !== 32'd7 || mispredict_count !== 32'd3) begin
      errs++; $display("FAIL idle_hold got cnt %0d/%0d exp 7/3", branch_count, mispredict_count);
    end
  endtask

  task automatic test_stall_correct();
    set_ex(1'b1, 1'b1, 1'b1, 64'h80, 64'h10, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++;
      if (branch_count !== 32'd7 || pc_redirect !== 1'b0) begin
        errs++; $display("FAIL stall_correct_%0d got cnt %0d redir %b exp 7 0", i, branch_count, pc_redirect);
      end
    end
    set_ex(1'b1, 1'b1, 1'b1, 64'h80, 64'h10, 1'b0);
    tick();
    set_ex(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    vecs++;
    if (branch_count !== 32'd8 || mispredict_count !== 32'd3) begin
      errs++; $display("FAIL stall_correct_count got %0d/%0d exp 8/3", branch_count, mispredict_count);
    end
  endtask

  task automatic test_reset_in_pending();
    set_ex(1'b1, 1'b1, 1'b0, 64'h300, 64'h10, 1'b1);
    tick();
    reset = 1'b0;
    #1;
    vecs++;
    if (branch_count !== 32'd0 || mispredict_count !== 32'd0 || pc_redirect !== 1'b0) begin
      errs++; $display("FAIL async_reset got cnt %0d/%0d redir %b exp 0/0 0", branch_count, mispredict_count, pc_redirect);
    end
    set_ex(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    vecs++;
    if (pc_redirect !== 1'b0) begin errs++; $display("FAIL reset_discard redir got %b exp 0", pc_redirect); end
    for (int i = 0; i < 16; i++) begin
      id_pc = 64'(i * 4);
      #1;
      vecs++;
      if (id_pred_taken !== 1'b0) begin errs++; $display("FAIL bht_reset_%0d got %b exp 0", i, id_pred_taken); end
    end
    tick();
  endtask

  task automatic test_alias_wrap();
    set_ex(1'b1, 1'b1, 1'b1, 64'h0, 64'h10, 1'b0);
    tick();
    id_pc = 64'h40;
    set_ex(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    vecs++;
    if (id_pred_taken !== 1'b1) begin errs++; $display("FAIL alias_up got %b exp 1", id_pred_taken); end
    set_ex(1'b1, 1'b0, 1'b0, 64'h40, 64'h10, 1'b0);
    tick();
    id_pc = 64'h0;
    set_ex(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    vecs++;
    if (id_pred_taken !== 1'b0 || branch_count !== 32'd2 || mispredict_count !== 32'd0) begin
      errs++; $display("FAIL alias_down got pred %b cnt %0d/%0d exp 0 2/0", id_pred_taken, branch_count, mispredict_count);
    end
    set_ex(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h100, 1'b0);
    vecs++;
    if (pc_redirect !== 1'b1 || redirect_target !== 64'h0) begin
      errs++; $display("FAIL wrap_target got %b tgt %h exp 1 tgt 0", pc_redirect, redirect_target);
    end
    tick();
    id_pc = 64'h3C;
    set_ex(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    vecs++;
    if (id_pred_taken !== 1'b0 || branch_count !== 32'd3 || mispredict_count !== 32'd1) begin
      errs++; $display("FAIL wrap_after got pred %b cnt %0d/%0d exp 0 3/1", id_pred_taken, branch_count, mispredict_count);
    end
  endtask

  initial begin
    test_reset();
    test_mispredict_taken();
    test_saturate();
    test_stall_pending();
    test_stall_correct();
    test_reset_in_pending();
    test_alias_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences control-flow recovery for the 5-stage RV64 pipeline.
- Holds a 2-bit branch history table (BHT) and supplies taken/not-taken predictions to ID.
- Takes the EX-stage branch outcome (the branch comparator's sel output) and detects mispredictions.
- Drives PC redirect and IF/ID, ID/EX flushes; keeps branch and mispredict performance counters.

Parameters:
- XLEN, 64, datapath/PC width.
- IDX_BITS, 4, BHT index width; 2**IDX_BITS entries.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- id_pc  input  XLEN  PC of instruction in ID; BHT lookup address.
- id_pred_taken  output  1  prediction for the ID-stage branch.
- ex_valid  input  1  EX holds a real (non-bubble) instruction.
- ex_branch  input  1  EX instruction is a conditional branch.
- ex_taken  input  1  branch comparator result for the EX instruction.
- ex_pred_taken  input  1  prediction carried down the pipe with the instruction.
- ex_pc  input  XLEN  PC of the EX instruction.
- ex_imm  input  XLEN  sign-extended branch offset.
- stall  input  1  hazard unit freeze of PC, IF/ID and ID/EX.
- pc_redirect  output  1  PC mux selects redirect_target this cycle.
- redirect_target  output  XLEN  corrected PC.
- flush_if_id  output  1  clear IF/ID at the next edge.
- flush_id_ex  output  1  clear ID/EX at the next edge.
- branch_count  output  CNT_W  resolved branches.
- mispredict_count  output  CNT_W  mispredicted branches.

Behaviour:
- Reset (reset=0, async): all BHT entries = 2'b01 (weakly not-taken); counters = 0; state = RUN; pending registers = 0.
- Outputs under reset: pc_redirect, flush_* and id_pred_taken = 0.
- BHT index = pc[IDX_BITS+1:2]; PC bits [1:0] are ignored.
- id_pred_taken = bht[idx(id_pc)][1], combinational.
- A BHT write and a read of the same index in one cycle: the read returns the old value.
- resolve = ex_valid & ex_branch. mispred = resolve & (ex_taken != ex_pred_taken).
- Target: ex_taken ? ex_pc+ex_imm : ex_pc+4. Both sums are modulo 2**XLEN.
- State RUN, stall=0, resolve=1:
  - BHT entry idx(ex_pc) saturating-increments if ex_taken, else decrements (11 stays 11, 00 stays 00).
  - branch_count increments.
  - If mispred: mispredict_count increments; pc_redirect, flush_if_id and flush_id_ex all =1 combinationally in the same cycle; redirect_target = target. Stay in RUN.
- State RUN, stall=1:
  - No BHT or counter update.
  - If mispred: latch target, idx(ex_pc) and ex_taken into pending registers, go to PENDING.
  - pc_redirect and flush_* stay 0 while stalled.
- State PENDING:
  - EX inputs ignored.
  - While stall=1: hold state, outputs 0.
  - First cycle with stall=0: pc_redirect=1, flush_if_id=1, flush_id_ex=1, redirect_target = latched target. Apply the BHT update from the latched idx/taken; increment both counters once. Return to RUN.
- Non-mispredicted branches seen under stall are counted once, in the first unstalled cycle they occupy EX (normal RUN rule).
- Redirect pulse is exactly one cycle per misprediction. ID/EX is cleared, so EX holds a bubble in the following cycle; no double redirect.
- resolve=0 or ex_valid=0: no update; pc_redirect and flush_* = 0.
- Counters saturate at 2**CNT_W-1 and do not wrap.
- reset asserted in PENDING: pending redirect is discarded; the block returns to RUN with the reset values.

Test Plan:
- Reset then id_pc=0x100 -> id_pred_taken=0; counters 0; all outputs 0.
- ex_pc=0x100, ex_imm=0x20, ex_taken=1, ex_pred_taken=0, stall=0 -> same cycle: pc_redirect=1, target=0x120, both flushes=1. Next cycle: bht[0]=10, id_pc=0x100 gives id_pred_taken=1, branch_count=1, mispredict_count=1.
- Three more taken, correctly predicted resolves at 0x100 -> no redirect; bht[0]=11 (saturated); branch_count=4. Then not-taken with ex_pred_taken=1 -> redirect to 0x104, bht[0]=10.
- Mispredict (target 0x2040) with stall=1 for 3 cycles; EX inputs changed to garbage during the stall -> no outputs while stalled. On the first stall=0 cycle: one pulse, target=0x2040, counters +1 once.
- Assert reset in PENDING, release with stall=0 -> no redirect pulse; counters 0; BHT all 01.
- ex_pc=0x0 and 0x40 (alias index 0 when IDX_BITS=4) -> both update the same entry. ex_pc=0xFFFF_FFFF_FFFF_FFFC, not-taken mispredict -> target wraps to 0x0.
